uart_recv: RTL and testbench

UART receiver, 8N1, LSB first, idle-high line, the receive-side counterpart of the team's UART transmitter. It synchronises the asynchronous serial input and detects the start bit. Each bit is sampled at its mid-point, and the block presents each received byte with a one-cycle valid pulse. A bad stop bit is reported as a framing error. It sits between the board RX pin and the byte-consumer logic, for example a loopback, display or command decoder.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_sync.sv | 28 ++
 rtl/uart_recv.sv | 96 +++++++++
 tb/tb_uart_recv.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit-period counter limit and
// the 2-bit state encoding common to the transmitter and receiver.
package uart_pkg;

  // 9600 baud from a 100 MHz clock: 10417 clk cycles per bit
  localparam int BAUD_CNT_MAX_DEFAULT = 10416;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the RX pin plus falling-edge detect.
// All flops reset high so a reset never looks like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic din_s,
  output logic fall
);

  logic meta;
  logic din_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta  <= 1'b1;
      din_s <= 1'b1;
      din_d <= 1'b1;
    end else begin
      meta  <= din;
      din_s <= meta;
      din_d <= din_s;
    end
  end

  assign fall = din_d & ~din_s;

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver: start detect, mid-bit sampling, LSB first,
// one-cycle valid per good byte and frame_err on a low stop bit.
module uart_recv
  import uart_pkg::*;
#(
  parameter int BAUD_CNT_MAX = BAUD_CNT_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       valid,
  output logic [7:0] data,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF_CNT = BAUD_CNT_MAX / 2;
  localparam int CW = $clog2(BAUD_CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_CNT_MAX);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_CNT);

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          din_s;
  logic          fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .din_s (din_s),
    .fall  (fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (fall) state <= START;
        end
        START: begin
          if (baud_cnt == CNT_HALF) begin
            baud_cnt <= '0;
            // a high line at mid-start was only a glitch
            state    <= din_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == CNT_MAX) begin
            baud_cnt  <= '0;
            shift_reg <= {din_s, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == CNT_MAX) begin
            // leave at mid-stop so the next start edge is never missed
            baud_cnt <= '0;
            state    <= IDLE;
            if (din_s) begin
              data  <= shift_reg;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_recv.sv
// Randomised self-checking bench for uart_recv with an outcome-queue
// model of the serial line and a per-cycle compare process.
module tb_uart_recv;

  localparam int B = 249;
  localparam int P = B + 1;
  // 2 (sync) + HALF_CNT+1 (125) + 9*P (2250) + 1 (registered pulse)
  localparam int LAT = 2378;

  logic       clk;
  logic       rst;
  logic       din;
  logic       valid;
  logic [7:0] data;
  logic       frame_err;
  logic       busy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       good;
    logic [7:0] val;
    int         t0;
    bit         timed;
  } exp_t;

  exp_t       q[$];
  logic [7:0] last_good = 8'h00;

  uart_recv #(.BAUD_CNT_MAX(B)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .valid     (valid),
    .data      (data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      last_good = 8'h00;
      checks++;
      if (valid || frame_err || busy || data != 8'h00)
        $display("FAIL reset_outs: v=%0b fe=%0b busy=%0b data=%h want 0/0/0/00",
                 valid, frame_err, busy, data);
      if (valid || frame_err || busy || data != 8'h00) errors++;
    end else begin
      if (valid || frame_err) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_pulse: v=%0b fe=%0b at cyc %0d, none expected",
                   valid, frame_err, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (valid === frame_err || valid !== e.good) begin
            errors++;
            $display("FAIL pulse_kind: v=%0b fe=%0b want good=%0b", valid,
                     frame_err, e.good);
          end
          if (e.good) last_good = e.val;
          if (e.timed) begin
            int d;
            d = cyc - e.t0 - LAT;
            checks++;
            if (d < -2 || d > 2) begin
              errors++;
              $display("FAIL latency: got %0d want %0d+-2", cyc - e.t0, LAT);
            end
          end
        end
      end
      checks++;
      if (data !== last_good) begin
        errors++;
        $display("FAIL data_hold: got %h want %h at cyc %0d", data,
                 last_good, cyc);
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input int p,
                            input logic stop, input bit push);
    if (push) q.push_back('{stop, b, cyc, p == P});
    din = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      repeat (p) @(negedge clk);
    end
    din = stop;
    repeat (p) @(negedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 3 * P) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d outcomes still pending", q.size());
      q.delete();
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  initial begin
    bit stuck;
    rst = 1'b1;
    din = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", valid, 0);
    check("reset_busy", busy, 0);
    check("reset_data", data, 8'h00);
    repeat (20) @(negedge clk);

    send_frame(8'hA5, P, 1'b1, 1);
    wait_drain();
    check("loop_a5", data, 8'hA5);
    repeat (30) @(negedge clk);

    send_frame(8'h00, P, 1'b1, 1);
    send_frame(8'hFF, P, 1'b1, 1);
    wait_drain();
    check("b2b_ff", data, 8'hFF);
    repeat (30) @(negedge clk);

    din = 1'b0;
    repeat (100) @(negedge clk);
    check("glitch_busy_hi", busy, 1);
    din = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_busy_lo", busy, 0);
    repeat (30) @(negedge clk);

    send_frame(8'h3C, P, 1'b0, 1);
    din = 1'b0;
    stuck = 1'b0;
    repeat (3 * P) begin
      @(negedge clk);
      if (busy) stuck = 1'b1;
    end
    check("break_idle", stuck, 0);
    check("ferr_keep", data, 8'hFF);
    din = 1'b1;
    repeat (30) @(negedge clk);

    din = 1'b0;
    repeat (P) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      din = (8'h5A >> i) & 8'h01;
      repeat (P) @(negedge clk);
    end
    din = 1'b1;
    repeat (P / 2) @(negedge clk);
    check("mid_busy", busy, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_data", data, 8'h00);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (30) @(negedge clk);
    send_frame(8'h81, P, 1'b1, 1);
    wait_drain();
    check("after_rst_81", data, 8'h81);
    repeat (30) @(negedge clk);

    send_frame(8'h55, P - 5, 1'b1, 1);
    wait_drain();
    check("skew_minus", data, 8'h55);
    din = 1'b1;
    repeat (40) @(negedge clk);
    last_good = last_good;
    send_frame(8'h55, P + 5, 1'b1, 1);
    wait_drain();
    check("skew_plus", data, 8'h55);
    repeat (30) @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      int         sel;
      logic [7:0] b;
      logic       stop;
      sel  = $urandom_range(0, 2);
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      send_frame(b, P - 5 + 5 * sel, stop, 1);
      wait_drain();
      din = 1'b1;
      repeat ($urandom_range(20, 300)) @(negedge clk);
    end

    wait_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
